// File: rtl/add_nbit_pipe.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream interface.
// The WIDTH-bit carry chain is cut into STAGES equal segments; each segment is
// a chain of 1-bit full adders fed by the carry registered one stage earlier.
// A single global stall (advance) moves or holds every stage together.
module add_nbit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $fatal(1, "add_nbit_pipe: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    // Stage registers: valid, delayed operands, partial result, segment carry.
    // Operand B is stored already inverted for subtraction, so the mode never
    // needs to travel down the pipe.
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] opa_q;
    logic [STAGES-1:0][WIDTH-1:0] opb_q;
    logic [STAGES-1:0][WIDTH-1:0] res_q;
    logic [STAGES-1:0]            cry_q;
    logic                         ovf_q;

    // Inputs seen by each stage's adder segment, and what it produces.
    logic [STAGES-1:0]            stg_v;
    logic [STAGES-1:0][WIDTH-1:0] stg_a;
    logic [STAGES-1:0][WIDTH-1:0] stg_b;
    logic [STAGES-1:0][WIDTH-1:0] stg_s;
    logic [STAGES-1:0]            stg_c;
    logic [STAGES-1:0][WIDTH-1:0] stg_r;
    logic [STAGES-1:0]            stg_co;

    logic advance;
    logic ovf_d;

    // The only input-to-output combinational path: ready follows the output slot.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 0 works directly on the ports; subtraction is a + ~b + 1.
    assign stg_v[0] = in_valid;
    assign stg_a[0] = a;
    assign stg_b[0] = sub ? ~b : b;
    assign stg_s[0] = '0;
    assign stg_c[0] = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   xa;
        logic [SEG-1:0]   xb;
        logic [SEG-1:0]   xs;
        logic             carry;
        logic [WIDTH-1:0] merged;

        assign xa = stg_a[k][k*SEG +: SEG];
        assign xb = stg_b[k][k*SEG +: SEG];

        // Chain of 1-bit full adders across this segment, then merge the new
        // slice into the result bits computed by earlier stages.
        always_comb begin
            carry = stg_c[k];
            xs    = '0;
            for (int unsigned i = 0; i < SEG; i++) begin
                xs[i] = xa[i] ^ xb[i] ^ carry;
                carry = (xa[i] & xb[i]) | (carry & (xa[i] ^ xb[i]));
            end
            merged               = stg_s[k];
            merged[k*SEG +: SEG] = xs;
        end

        assign stg_r[k]  = merged;
        assign stg_co[k] = carry;

        if (k > 0) begin : g_link
            assign stg_v[k] = vld_q[k-1];
            assign stg_a[k] = opa_q[k-1];
            assign stg_b[k] = opb_q[k-1];
            assign stg_s[k] = res_q[k-1];
            assign stg_c[k] = cry_q[k-1];
        end
    end

    // Signed overflow is decided when the MSB segment is formed.
    assign ovf_d = (stg_a[LAST][WIDTH-1] == stg_b[LAST][WIDTH-1]) &&
                   (stg_r[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);

    // Pipeline register: clear on reset, shift all stages on advance, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            vld_q <= stg_v;
            opa_q <= stg_a;
            opb_q <= stg_b;
            res_q <= stg_r;
            cry_q <= stg_co;
            ovf_q <= ovf_d;
        end
    end

    // Operands held in the final stage have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{opa_q[LAST], opb_q[LAST]};

    assign out_valid = vld_q[LAST];
    assign sum       = res_q[LAST];
    assign cout      = cry_q[LAST];
    assign ovf       = ovf_q;

    // A presented but unaccepted result must stay put.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(sum) && $stable(cout) && $stable(ovf))
    ) else $error("add_nbit_pipe: output changed while stalled");

endmodule

// File: tb/tb_add_nbit_pipe.sv
// Bench for add_nbit_pipe: five configurations share one stimulus stream, each
// with its own arithmetic reference model and per-cycle compare, plus literal
// expectations on the (8,2) instance.
module tb_add_nbit_pipe;

    localparam int NC = 5;

    function automatic int cfg_w(input int g);
        case (g)
            0: return 8;
            1: return 1;
            2: return 8;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_s(input int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 1;
            3: return 8;
            default: return 4;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [15:0] a16;
    logic [15:0] b16;

    logic [NC-1:0]        ready_w;
    logic [NC-1:0]        ov_w;
    logic [NC-1:0]        co_w;
    logic [NC-1:0]        of_w;
    logic [NC-1:0][15:0]  sum_w;

    logic chk_en;
    int   n_chk;
    int   n_err;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);

        logic         d_ready;
        logic         d_ov;
        logic         d_co;
        logic         d_of;
        logic [W-1:0] d_sum;

        add_nbit_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (d_ready),
            .a         (a16[W-1:0]),
            .b         (b16[W-1:0]),
            .cin       (cin),
            .sub       (sub),
            .out_valid (d_ov),
            .out_ready (out_ready),
            .sum       (d_sum),
            .cout      (d_co),
            .ovf       (d_of)
        );

        assign ready_w[g] = d_ready;
        assign ov_w[g]    = d_ov;
        assign co_w[g]    = d_co;
        assign of_w[g]    = d_of;
        assign sum_w[g]   = 16'(d_sum);

        // Integer arithmetic: unsigned result and carry/no-borrow, signed range test for overflow.
        function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ci, input logic sb);
            int   m, ux, uy, sx, sy, u, s;
            logic co, of;
            m  = 1 << W;
            ux = int'(x);
            uy = int'(y);
            sx = (ux >= m / 2) ? ux - m : ux;
            sy = (uy >= m / 2) ? uy - m : uy;
            if (sb) begin
                u  = ux - uy;
                co = (ux >= uy);
                s  = sx - sy;
            end else begin
                u  = ux + uy + int'(ci);
                co = (u >= m);
                s  = sx + sy + int'(ci);
            end
            of = (s >= m / 2) || (s < -(m / 2));
            u  = (u + m) % m;
            return {of, co, u[W-1:0]};
        endfunction

        // Latency-S delay line with a global stall; beats enter when the model is ready.
        logic [S-1:0]  m_v;
        logic [W+1:0]  m_d [S];
        logic          m_adv;
        assign m_adv = !m_v[S-1] || out_ready;

        always @(posedge clk) begin
            if (rst) begin
                m_v <= '0;
                for (int i = 0; i < S; i++) m_d[i] <= '0;
            end else if (m_adv) begin
                m_v[0] <= in_valid;
                m_d[0] <= golden(a16[W-1:0], b16[W-1:0], cin, sub);
                for (int i = 1; i < S; i++) begin
                    m_v[i] <= m_v[i-1];
                    m_d[i] <= m_d[i-1];
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                n_chk++;
                if (d_ov !== m_v[S-1]) begin
                    n_err++;
                    $display("FAIL cfg%0d out_valid: got %b expected %b", g, d_ov, m_v[S-1]);
                end
                n_chk++;
                if (d_ready !== m_adv) begin
                    n_err++;
                    $display("FAIL cfg%0d in_ready: got %b expected %b", g, d_ready, m_adv);
                end
                if (m_v[S-1] === 1'b1) begin
                    n_chk++;
                    if ({d_of, d_co, d_sum} !== m_d[S-1]) begin
                        n_err++;
                        $display("FAIL cfg%0d result {ovf,cout,sum}: got %0h expected %0h",
                                 g, {d_of, d_co, d_sum}, m_d[S-1]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s);
        in_valid = v;
        a16      = x;
        b16      = y;
        cin      = c;
        sub      = s;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_out0(input string nm, input logic [7:0] s, input logic c, input logic o);
        chk({nm, " out_valid"}, 32'(ov_w[0]), 32'h1);
        chk({nm, " sum"},       32'(sum_w[0][7:0]), 32'(s));
        chk({nm, " cout"},      32'(co_w[0]), 32'(c));
        chk({nm, " ovf"},       32'(of_w[0]), 32'(o));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        n_chk     = 0;
        n_err     = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state on every configuration.
        chk("reset out_valid", 32'(ov_w), 32'h0);
        chk("reset in_ready",  32'(ready_w), 32'(5'h1f));
        chk("reset cout",      32'(co_w), 32'h0);
        chk("reset ovf",       32'(of_w), 32'h0);
        for (int g = 0; g < NC; g++) chk("reset sum", 32'(sum_w[g]), 32'h0);

        // Add: carry wrap, then signed overflow.
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk_out0("add FF+01", 8'h00, 1'b1, 1'b0);
        tick();
        chk_out0("add 7F+01", 8'h80, 1'b0, 1'b1);
        repeat (3) tick();

        // Subtract with cin held high (ignored).
        drive(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'h0080, 16'h0001, 1'b1, 1'b1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk_out0("sub 05-07", 8'hFE, 1'b0, 1'b0);
        tick();
        chk_out0("sub 80-01", 8'h7F, 1'b1, 1'b1);
        repeat (3) tick();

        // Backpressure: two beats fill the pipe, third is held off.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 16'h0010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0003, 16'h0010, 1'b0, 1'b0);
        chk("bp in_ready low", 32'(ready_w[0]), 32'h0);
        chk_out0("bp first", 8'h11, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            chk("bp stall in_ready", 32'(ready_w[0]), 32'h0);
            chk_out0("bp stall", 8'h11, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        drive(1'b1, 16'h0004, 16'h0010, 1'b0, 1'b0);
        chk_out0("bp drain 2", 8'h12, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk_out0("bp drain 3", 8'h13, 1'b0, 1'b0);
        tick();
        chk_out0("bp drain 4", 8'h14, 1'b0, 1'b0);
        tick();
        chk("bp empty", 32'(ov_w[0]), 32'h0);
        repeat (10) tick();

        // Reset mid-stream: in-flight beats vanish.
        drive(1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("rst mid out_valid", 32'(ov_w), 32'h0);
        chk("rst mid in_ready",  32'(ready_w), 32'(5'h1f));
        chk("rst mid cout",      32'(co_w), 32'h0);
        chk("rst mid ovf",       32'(of_w), 32'h0);
        for (int g = 0; g < NC; g++) chk("rst mid sum", 32'(sum_w[g]), 32'h0);
        repeat (10) begin
            tick();
            chk("rst no stale beat", 32'(ov_w), 32'h0);
        end

        // Full throughput with alternating add/sub.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2));
            tick();
            cnt += int'(ov_w[0]);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            cnt += int'(ov_w[0]);
        end
        chk("throughput beats out", 32'(cnt), 32'd20);

        // Random stream with random valid/ready at 70%.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a16       = 16'($urandom);
            b16       = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("drained", 32'(ov_w), 32'h0);

        if (n_err == 0) $display("Simulation Passed");
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
